// File: rtl/mem_access_ctrl.sv
// Single-port RAM access sequencer: latches a request, holds the RAM interface
// for WAIT_CYCLES+1 cycles, then pulses done and captures read data.
module mem_access_ctrl #(
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // WAIT_CYCLES must stay within 0..15 so the load value fits the counter
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t              state;
  state_t              state_nxt;
  logic [3:0]          wait_cnt;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [DATA_W-1:0]   rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = ACCESS;
      ACCESS:  if (wait_cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latches, wait counter and read capture; inputs are only looked at in IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt  <= 4'd0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            lat_we    <= we;
            lat_addr  <= addr;
            lat_wdata <= wdata;
            wait_cnt  <= WAIT_INIT;
          end
        end
        ACCESS: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else if (!lat_we) begin
            rdata_q <= ram_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state == ACCESS);
  assign done      = (state == DONE);
  assign ram_en    = (state == ACCESS);
  assign ram_we    = (state == ACCESS) && lat_we;
  assign ram_addr  = lat_addr;
  assign ram_wdata = lat_wdata;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: two instances (WAIT_CYCLES=2 and 0),
// stimulus pushes expected transactions, a negedge monitor checks the RAM side.
module tb_mem_access_ctrl;

  localparam int AW  = 13;
  localparam int DW  = 16;
  localparam int W_A = 2;
  localparam int W_B = 0;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            first;
    int            done_at;
  } exp_t;

  logic clk = 1'b0;
  logic rst [2];
  logic req [2];
  logic we  [2];
  logic [AW-1:0] addr      [2];
  logic [DW-1:0] wdata     [2];
  logic [DW-1:0] ram_rdata [2];
  logic busy   [2];
  logic done   [2];
  logic ram_en [2];
  logic ram_we [2];
  logic [AW-1:0] ram_addr  [2];
  logic [DW-1:0] ram_wdata [2];
  logic [DW-1:0] rdata     [2];

  exp_t q0[$];
  exp_t q1[$];
  int   run        [2];
  int   first_seen [2];
  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W_A)) dut_a (
    .clk(clk), .rst(rst[0]), .req(req[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
    .busy(busy[0]), .done(done[0]), .rdata(rdata[0]), .ram_en(ram_en[0]), .ram_we(ram_we[0]),
    .ram_addr(ram_addr[0]), .ram_wdata(ram_wdata[0]), .ram_rdata(ram_rdata[0])
  );

  mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W_B)) dut_b (
    .clk(clk), .rst(rst[1]), .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
    .busy(busy[1]), .done(done[1]), .rdata(rdata[1]), .ram_en(ram_en[1]), .ram_we(ram_we[1]),
    .ram_addr(ram_addr[1]), .ram_wdata(ram_wdata[1]), .ram_rdata(ram_rdata[1])
  );

  function automatic int wait_of(input int k);
    return (k == 0) ? W_A : W_B;
  endfunction

  // RAM contents as seen by reads; 0x0ABC holds 0x1234, elsewhere addr ^ 0x5A5A
  function automatic logic [DW-1:0] ram_model(input logic [AW-1:0] a);
    if (a == 13'h0ABC) return 16'h1234;
    return {3'b000, a} ^ 16'h5A5A;
  endfunction

  task automatic checkOutput(input string name, input int k, input logic [31:0] act,
                             input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s[dut%0d]: got %0h, expected %0h (edge %0d)", name, k, act, exp, edge_cnt);
    end
  endtask

  task automatic push_exp(input int k, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] rd, input int first);
    exp_t e;
    e.we      = w;
    e.addr    = a;
    e.wdata   = d;
    e.rdata   = rd;
    e.first   = first;
    e.done_at = first + wait_of(k) + 1;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle request pulse; called #1 after an edge so the next edge samples it
  task automatic applyStimulus(input int k, input logic w, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic [DW-1:0] rd);
    push_exp(k, w, a, d, rd, edge_cnt + 1);
    req[k]   = 1'b1;
    we[k]    = w;
    addr[k]  = a;
    wdata[k] = d;
    step(1);
    req[k] = 1'b0;
  endtask

  task automatic monitor_step(input int k);
    exp_t h;
    bit   have;
    have = (k == 0) ? (q0.size() != 0) : (q1.size() != 0);
    if (have) h = (k == 0) ? q0[0] : q1[0];
    ram_rdata[k] = 16'hDEAD;
    if (ram_en[k] === 1'b1) begin
      if (!have) begin
        checkOutput("idle_no_access", k, 32'(ram_en[k]), 32'd0);
      end else begin
        run[k]++;
        if (run[k] == 1) first_seen[k] = edge_cnt;
        checkOutput("access_addr", k, 32'(ram_addr[k]), 32'(h.addr));
        checkOutput("access_we", k, 32'(ram_we[k]), 32'(h.we));
        checkOutput("access_wdata", k, 32'(ram_wdata[k]), 32'(h.wdata));
        checkOutput("access_busy", k, 32'(busy[k]), 32'd1);
        if (run[k] == wait_of(k) + 1) ram_rdata[k] = ram_model(ram_addr[k]);
      end
    end
    if (done[k] === 1'b1) begin
      if (!have) begin
        checkOutput("no_spurious_done", k, 32'(done[k]), 32'd0);
      end else begin
        checkOutput("first_access_edge", k, 32'(first_seen[k]), 32'(h.first));
        checkOutput("done_edge", k, 32'(edge_cnt), 32'(h.done_at));
        checkOutput("access_len", k, 32'(run[k]), 32'(wait_of(k) + 1));
        checkOutput("rdata", k, 32'(rdata[k]), 32'(h.rdata));
        checkOutput("done_busy", k, 32'(busy[k]), 32'd0);
        checkOutput("done_ram_en", k, 32'(ram_en[k]), 32'd0);
        checkOutput("done_ram_we", k, 32'(ram_we[k]), 32'd0);
        if (k == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
        run[k] = 0;
      end
    end
    // A reset at the coming edge aborts whatever is in flight
    if (rst[k] === 1'b1) begin
      if (k == 0) q0.delete();
      else        q1.delete();
      run[k] = 0;
    end
  endtask

  always @(negedge clk) begin
    monitor_step(0);
    monitor_step(1);
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k]   = 1'b1;
      req[k]   = 1'b0;
      we[k]    = 1'b0;
      addr[k]  = '0;
      wdata[k] = '0;
    end
    step(2);
    for (int k = 0; k < 2; k++) begin
      checkOutput("rst_busy", k, 32'(busy[k]), 32'd0);
      checkOutput("rst_done", k, 32'(done[k]), 32'd0);
      checkOutput("rst_ram_en", k, 32'(ram_en[k]), 32'd0);
      checkOutput("rst_ram_we", k, 32'(ram_we[k]), 32'd0);
      checkOutput("rst_ram_addr", k, 32'(ram_addr[k]), 32'd0);
      checkOutput("rst_ram_wdata", k, 32'(ram_wdata[k]), 32'd0);
      checkOutput("rst_rdata", k, 32'(rdata[k]), 32'd0);
    end
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    step(2);

    $display("[TB] read 0x0ABC, WAIT_CYCLES=2");
    applyStimulus(0, 1'b0, 13'h0ABC, 16'h0000, 16'h1234);
    step(6);

    $display("[TB] write 0x1FFF <= 0xBEEF");
    applyStimulus(0, 1'b1, 13'h1FFF, 16'hBEEF, 16'h1234);
    step(6);

    $display("[TB] request while busy");
    applyStimulus(0, 1'b0, 13'h0010, 16'h0000, 16'h5A4A);
    req[0]   = 1'b1;
    we[0]    = 1'b1;
    addr[0]  = 13'h0005;
    wdata[0] = 16'hFFFF;
    step(2);
    req[0] = 1'b0;
    step(6);

    $display("[TB] reset in second access cycle");
    applyStimulus(0, 1'b0, 13'h0020, 16'h0000, 16'h5A7A);
    step(1);
    rst[0] = 1'b1;
    step(1);
    checkOutput("abort_ram_en", 0, 32'(ram_en[0]), 32'd0);
    checkOutput("abort_busy", 0, 32'(busy[0]), 32'd0);
    checkOutput("abort_done", 0, 32'(done[0]), 32'd0);
    checkOutput("abort_rdata", 0, 32'(rdata[0]), 32'd0);
    rst[0] = 1'b0;

    $display("[TB] request on first edge after reset");
    applyStimulus(0, 1'b0, 13'h0001, 16'h0000, 16'h5A5B);
    step(6);

    $display("[TB] reset and request on the same edge");
    rst[0]  = 1'b1;
    req[0]  = 1'b1;
    we[0]   = 1'b0;
    addr[0] = 13'h0ABC;
    step(1);
    rst[0] = 1'b0;
    req[0] = 1'b0;
    checkOutput("collide_busy", 0, 32'(busy[0]), 32'd0);
    checkOutput("collide_ram_en", 0, 32'(ram_en[0]), 32'd0);
    checkOutput("collide_ram_addr", 0, 32'(ram_addr[0]), 32'd0);
    step(4);
    checkOutput("collide_idle_busy", 0, 32'(busy[0]), 32'd0);
    checkOutput("collide_rdata", 0, 32'(rdata[0]), 32'd0);

    $display("[TB] WAIT_CYCLES=0 back-to-back reads, req held");
    push_exp(1, 1'b0, 13'h0000, 16'h0000, 16'h5A5A, edge_cnt + 1);
    req[1]  = 1'b1;
    we[1]   = 1'b0;
    addr[1] = 13'h0000;
    step(1);
    push_exp(1, 1'b0, 13'h0001, 16'h0000, 16'h5A5B, edge_cnt + 3);
    addr[1] = 13'h0001;
    step(3);
    req[1] = 1'b0;
    step(8);

    checkOutput("queue_a_drained", 0, 32'(q0.size()), 32'd0);
    checkOutput("queue_b_drained", 1, 32'(q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter ADDR_W, default 13, address width; matches the memory address register output.
REQ-002 Parameter DATA_W, default 16, data word width.
REQ-003 Parameter WAIT_CYCLES, default 2, extra RAM wait cycles per access; legal range 0..15.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req  input  1  access request; sampled only in IDLE.
REQ-007 we  input  1  1 = write, 0 = read; sampled with req.
REQ-008 addr  input  ADDR_W  word address, driven by the memory address register output.
REQ-009 wdata  input  DATA_W  write data; sampled with req.
REQ-010 busy  output  1  high while an access is in progress.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 rdata  output  DATA_W  last read result; registered.
REQ-013 ram_en  output  1  RAM enable.
REQ-014 ram_we  output  1  RAM write strobe.
REQ-015 ram_addr  output  ADDR_W  RAM address.
REQ-016 ram_wdata  output  DATA_W  RAM write data.
REQ-017 ram_rdata  input  DATA_W  RAM read data; valid in the final access cycle.

Function
REQ-018 FSM states: IDLE, ACCESS, DONE; one-hot or binary encoding is acceptable.
REQ-019 In IDLE, req=1 at an edge:
  - latches addr, we, wdata into internal registers;
  - loads wait counter with WAIT_CYCLES;
  - moves to ACCESS.
REQ-020 In IDLE, req=0 holds IDLE with no output changes.
REQ-021 ACCESS outputs:
  - ram_en=1 and busy=1;
  - ram_addr and ram_wdata = latched values;
  - ram_we = latched we.
REQ-022 ACCESS lasts exactly WAIT_CYCLES+1 cycles:
  - counter decrements each edge while nonzero;
  - counter==0 at an edge moves the FSM to DONE.
REQ-023 At the ACCESS->DONE edge of a read, rdata captures ram_rdata; a write leaves rdata unchanged.
REQ-024 DONE outputs and transition:
  - done=1, busy=0, ram_en=0, ram_we=0;
  - unconditionally returns to IDLE on the next edge.
REQ-025 Latency: req sampled at edge N -> ACCESS cycles N+1..N+1+WAIT_CYCLES -> done high in cycle N+2+WAIT_CYCLES.
REQ-026 Sustained back-to-back throughput is one access per WAIT_CYCLES+3 cycles.
REQ-027 req in ACCESS or DONE is ignored and not queued; addr/we/wdata changes during ACCESS do not affect RAM outputs.
REQ-028 ram_addr and ram_wdata retain their last latched values in IDLE and DONE.
REQ-029 All outputs derive from registers/state only; no combinational path from any input to any output.
REQ-030 With WAIT_CYCLES=0, ACCESS lasts exactly one cycle.
REQ-031 The counter is 4 bits wide and never underflows.

Reset
REQ-032 rst=1 at an edge forces, regardless of state:
  - state IDLE, counter 0;
  - busy, done, ram_en, ram_we = 0;
  - ram_addr, ram_wdata, rdata and internal latches = 0.
REQ-033 Reset during ACCESS aborts the access:
  - ram_en and ram_we drop on that edge;
  - no done pulse is produced;
  - rdata reads 0.
REQ-034 rst has priority over req on the same edge; req is not latched.
REQ-035 A req asserted on the first edge after rst deasserts is accepted normally.

Verification
REQ-036 Read, WAIT_CYCLES=2:
  - stimulus: req=1, we=0, addr=13'h0ABC at edge 0; RAM returns 16'h1234 in cycle 3.
  - response: ram_en=1, ram_addr=13'h0ABC for cycles 1-3; done=1 in cycle 4; rdata=16'h1234 from cycle 4.
REQ-037 Write:
  - stimulus: req=1, we=1, addr=13'h1FFF, wdata=16'hBEEF.
  - response: ram_we=1, ram_wdata=16'hBEEF, ram_addr=13'h1FFF for three cycles; done pulses once; rdata unchanged.
REQ-038 Request while busy:
  - stimulus: during ACCESS, req=1 with addr=13'h0005.
  - response: ram_addr keeps the original address; no second access follows DONE unless req is high in IDLE.
REQ-039 Reset mid-access:
  - stimulus: rst=1 in the second ACCESS cycle.
  - response: next cycle ram_en=0, busy=0, done=0, rdata=0; no done pulse follows.
REQ-040 WAIT_CYCLES=0, back-to-back reads of addr 0 then 1 with req held high:
  - accesses in cycles 1 and 4;
  - done in cycles 2 and 5.
REQ-041 Reset/req collision:
  - stimulus: rst=1 and req=1 on the same edge.
  - response: stays IDLE, busy=0, ram_en=0.
